// File: rtl/logic_accum_pkg.sv
// Shared definitions for the streaming bitwise accumulator: fold-mode
// encodings and the controller state type.
package logic_accum_pkg;

    localparam int unsigned MODE_W = 2;

    localparam logic [MODE_W-1:0] MODE_OR  = 2'b00;
    localparam logic [MODE_W-1:0] MODE_AND = 2'b01;
    localparam logic [MODE_W-1:0] MODE_XOR = 2'b10;
    localparam logic [MODE_W-1:0] MODE_NOR = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage : logic_accum_pkg

// File: rtl/logic_accum_bitwise_op.sv
// bitwise_op: combinational two-operand WIDTH-bit OR/AND/XOR selector.
// Ports:
//   a, b      operands
//   mode      fold mode; NOR folds with OR (the inversion happens at the output)
//   result_c  combinational result
module bitwise_op
    import logic_accum_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic [MODE_W-1:0] mode,
    output logic [WIDTH-1:0]  result_c
);

    // Pure bitwise select, no carries between lanes.
    always_comb begin
        result_c = a | b;
        case (mode)
            MODE_AND: result_c = a & b;
            MODE_XOR: result_c = a ^ b;
            default:  result_c = a | b;
        endcase
    end

endmodule : bitwise_op

// File: rtl/logic_accum.sv
// logic_accum: streaming bitwise reduction unit. Folds a handshaked burst of
// WIDTH-bit words through OR/AND/XOR/NOR into one result with a zero flag.
// Ports:
//   clk, rst_n                       clock, synchronous active-low reset
//   in_valid/in_ready                input beat handshake
//   in_data, in_last, in_mode        word, end-of-burst, mode (first beat only)
//   out_valid/out_ready              result handshake
//   out_data, out_zero               reduced word and its zero flag
//   out_count, out_ovf               words folded (saturating), overflow flag
module logic_accum
    import logic_accum_pkg::*;
#(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned MAX_WORDS = 8
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [WIDTH-1:0]                 in_data,
    input  logic                             in_last,
    input  logic [MODE_W-1:0]                in_mode,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [WIDTH-1:0]                 out_data,
    output logic                             out_zero,
    output logic [$clog2(MAX_WORDS+1)-1:0]   out_count,
    output logic                             out_ovf
);

    localparam int unsigned CNT_W = $clog2(MAX_WORDS + 1);

    state_t              state;
    logic [WIDTH-1:0]    acc;
    logic [MODE_W-1:0]   mode_q;
    logic [CNT_W-1:0]    count;
    logic                ovf;

    logic                accept_c;
    logic [WIDTH-1:0]    fold_c;
    logic [WIDTH-1:0]    acc_nxt_c;
    logic [MODE_W-1:0]   mode_nxt_c;
    logic [CNT_W-1:0]    cnt_nxt_c;
    logic                ovf_nxt_c;
    logic [WIDTH-1:0]    res_c;

    assign accept_c = in_valid && in_ready;

    bitwise_op #(.WIDTH(WIDTH)) u_op (
        .a        (acc),
        .b        (in_data),
        .mode     (mode_q),
        .result_c (fold_c)
    );

    // Next accumulator contents for an accepted beat; also gives the final
    // result directly so out_data can be registered on the last beat.
    always_comb begin
        acc_nxt_c  = acc;
        mode_nxt_c = mode_q;
        cnt_nxt_c  = count;
        ovf_nxt_c  = ovf;
        if (state == IDLE) begin
            acc_nxt_c  = in_data;
            mode_nxt_c = in_mode;
            cnt_nxt_c  = CNT_W'(1);
            ovf_nxt_c  = 1'b0;
        end else if (count < CNT_W'(MAX_WORDS)) begin
            acc_nxt_c = fold_c;
            cnt_nxt_c = count + CNT_W'(1);
        end else begin
            // Saturated: beat is consumed but not folded.
            ovf_nxt_c = 1'b1;
        end
        res_c = (mode_nxt_c == MODE_NOR) ? ~acc_nxt_c : acc_nxt_c;
    end

    // Controller, datapath registers and registered handshake/result outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            mode_q    <= MODE_OR;
            count     <= '0;
            ovf       <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_zero  <= 1'b1;
            out_count <= '0;
            out_ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE, ACCUM: begin
                    in_ready <= 1'b1;
                    if (accept_c) begin
                        acc    <= acc_nxt_c;
                        mode_q <= mode_nxt_c;
                        count  <= cnt_nxt_c;
                        ovf    <= ovf_nxt_c;
                        if (in_last) begin
                            state     <= DONE;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                            out_data  <= res_c;
                            out_zero  <= (res_c == '0);
                            out_count <= cnt_nxt_c;
                            out_ovf   <= ovf_nxt_c;
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule : logic_accum

// File: doc/logic_accum.md
# logic_accum

Parametrised streaming bitwise accumulator for the Hack datapath: folds a burst of WIDTH-bit words through OR, AND, XOR or NOR into one result word with a zero flag. It generalises our fixed 16-bit combinational gate banks into a sequential, handshaked reduction unit. It sits between a word source (RAM/stream reader) and the ALU/flag consumer.

## Interface
- WIDTH, 16, data word width (≥1)
- MAX_WORDS, 8, maximum words folded per burst (≥2); CNT_W = $clog2(MAX_WORDS+1)
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  source presents a word
- in_ready  out  1  block accepts a word this cycle
- in_data  in  WIDTH  word
- in_last  in  1  final word of burst
- in_mode  in  2  00 OR, 01 AND, 10 XOR, 11 NOR; sampled on first beat only
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- out_data  out  WIDTH  reduced word
- out_zero  out  1  out_data == 0
- out_count  out  CNT_W  words folded (saturates at MAX_WORDS)
- out_ovf  out  1  burst exceeded MAX_WORDS; excess words discarded

## Operation
- Beat accepted when in_valid && in_ready.
- States: IDLE, ACCUM, DONE.
- IDLE: in_ready=1, out_valid=0. On accept: acc<=in_data, mode_q<=in_mode, count<=1, ovf<=0; next = in_last ? DONE : ACCUM.
- ACCUM: in_ready=1. On accept: if count<MAX_WORDS, acc<=op(acc,in_data), count<=count+1; else acc and count held, ovf<=1. in_last accepted → DONE. No accept → hold.
- DONE: in_ready=0, out_valid=1. out_data = (mode_q==NOR) ? ~acc : acc; AND/OR/XOR output acc unchanged. out_zero = (out_data==0), computed on the output value. On out_ready → IDLE.
- op: OR/NOR use a|b, AND a&b, XOR a^b; pure bitwise, no carries.
- in_mode ignored on non-first beats.
- Outputs out_data/out_count/out_ovf hold stable while out_valid=1 and out_ready=0.

## Timing
- Reset (rst_n low at edge): state=IDLE, acc=0, count=0, ovf=0, mode_q=OR; outputs in_ready=1 after reset release, out_valid=0, out_data=0, out_zero=1, out_count=0, out_ovf=0. During the reset cycle in_ready=0.
- Reset mid-burst or in DONE: partial result discarded, no out_valid.
- in_ready and out_valid are decoded from registered state only (no combinational path from out_ready or in_valid).
- Latency: last beat accepted at edge T → out_valid high from T+1.
- Single-word burst: accepted at T, out_valid at T+1.
- Throughput: one beat/cycle in ACCUM; one idle cycle between bursts (output handshake at T, in_ready=1 from T+1).
- Overflow boundary: word MAX_WORDS folded normally; word MAX_WORDS+1 onward sets ovf, still accepted, not folded.

## Structure
- Package logic_accum_pkg: mode localparams (MODE_OR/AND/XOR/NOR), state enum (IDLE/ACCUM/DONE).
- Sub-module bitwise_op: combinational WIDTH-bit two-operand OR/AND/XOR selector; top holds FSM, counter, registers, NOR inversion, zero detect.

## Test plan
- Reset then OR burst 0x0001,0x0010,0x0100,0x1000(last) → out_data=0x1111, out_zero=0, out_count=4, out_ovf=0, out_valid one cycle after last.
- AND burst 0xFFFF,0x0F0F,0x00FF(last) with mode=01 on first beat and mode=10 on later beats → out_data=0x000F, count=3.
- XOR single-word 0xA5A5(last) then XOR pair 0xA5A5,0xA5A5 → 0xA5A5 zero=0; then 0x0000 zero=1, count=2.
- NOR burst 0x00FF,0xFF00(last) → out_data=0x0000, out_zero=1; hold out_ready=0 for 5 cycles → outputs stable, in_ready=0.
- MAX_WORDS=8, OR burst of 10 words 1<<i (i=0..9) → out_data=0x00FF, out_count=8, out_ovf=1.
- rst_n low mid-burst after 3 words, then OR burst 0x8000(last) → out_data=0x8000, count=1, ovf=0; no stale result emitted.
